// File: rtl/oh_clockor_ctrl.sv
// oh_clockor_ctrl: break-before-make select controller
// for an N-input one-hot clock OR tree.
module oh_clockor_ctrl #(
  parameter int N = 4,
  parameter int GAP = 4,
  parameter int DEFAULT = 0,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          sel_valid,
  input  logic          sel_off,
  input  logic [SW-1:0] sel,
  output logic          sel_ready,
  output logic [N-1:0]  en,
  output logic [SW-1:0] cur_sel,
  output logic          cur_on,
  output logic          busy,
  output logic          err
);

  localparam int CW = $clog2(GAP + 1);
  localparam logic [N-1:0] ONE = N'(1);
  localparam logic [N-1:0] DEF_EN = ONE << DEFAULT;
  localparam logic [SW-1:0] DEF_SEL = SW'(DEFAULT);
  localparam logic [CW-1:0] CNT_INIT = CW'(GAP);
  localparam logic [SW:0] NLIM = (SW+1)'(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_ON
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] tgt;
  logic          tgt_off;
  logic          sel_bad;
  logic          sel_same;
  logic          off_nop;

  // classify the request presented this cycle
  always_comb begin
    sel_bad  = !sel_off && ({1'b0, sel} >= NLIM);
    sel_same = !sel_off && cur_on && (sel == cur_sel);
    off_nop  = sel_off && !cur_on;
  end

  // select FSM: IDLE -> GAP (all off) -> ON -> IDLE
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tgt       <= DEF_SEL;
      tgt_off   <= 1'b0;
      en        <= DEF_EN;
      cur_sel   <= DEF_SEL;
      cur_on    <= 1'b1;
      sel_ready <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (sel_valid) begin
            unique case (1'b1)
              sel_bad: err <= 1'b1;
              sel_same, off_nop: ;
              default: begin
                tgt       <= sel;
                tgt_off   <= sel_off;
                en        <= '0;
                cur_on    <= 1'b0;
                cnt       <= CNT_INIT;
                state     <= S_GAP;
                sel_ready <= 1'b0;
                busy      <= 1'b1;
              end
            endcase
          end
        end
        S_GAP: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= S_ON;
            if (!tgt_off) begin
              en      <= ONE << tgt;
              cur_sel <= tgt;
              cur_on  <= 1'b1;
            end
          end
        end
        S_ON: begin
          state     <= S_IDLE;
          sel_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oh_clockor_ctrl.sv
// tb_oh_clockor_ctrl: table + scoreboard bench
// for the clock OR select controller.
module tb_oh_clockor_ctrl;

  localparam int GAP = 4;
  localparam logic [3:0] DEF_EN = 4'b0100;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  logic       sel_valid = 1'b0;
  logic       sel_off = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       sel_ready, cur_on, busy, err;
  logic [3:0] en;
  logic [1:0] cur_sel;

  oh_clockor_ctrl #(.N(4), .GAP(GAP), .DEFAULT(2)) dut (
    .clk(clk), .nreset(nreset),
    .sel_valid(sel_valid), .sel_off(sel_off), .sel(sel),
    .sel_ready(sel_ready), .en(en), .cur_sel(cur_sel),
    .cur_on(cur_on), .busy(busy), .err(err)
  );

  logic       v3 = 1'b0;
  logic       o3 = 1'b0;
  logic [1:0] s3 = 2'd0;
  logic       r3, on3, b3, e3;
  logic [2:0] en3;
  logic [1:0] cs3;

  oh_clockor_ctrl #(.N(3), .GAP(1), .DEFAULT(0)) dut3 (
    .clk(clk), .nreset(nreset),
    .sel_valid(v3), .sel_off(o3), .sel(s3),
    .sel_ready(r3), .en(en3), .cur_sel(cs3),
    .cur_on(on3), .busy(b3), .err(e3)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] en;
    logic       rdy;
    logic       bsy;
    logic       on;
    logic       er;
  } obs_t;

  obs_t sb[$];

  function automatic obs_t now_obs();
    return '{en: en, rdy: sel_ready, bsy: busy, on: cur_on, er: err};
  endfunction

  task automatic push(logic [3:0] e, logic rdy, logic on, logic er);
    sb.push_back('{en: e, rdy: rdy, bsy: !rdy, on: on, er: er});
  endtask

  task automatic push_switch(logic [3:0] e, logic on);
    repeat (GAP) push(4'b0000, 1'b0, 1'b0, 1'b0);
    push(e, 1'b0, on, 1'b0);
    push(e, 1'b1, on, 1'b0);
  endtask

  task automatic drain(string nm, int drop_k, logic [1:0] resel);
    obs_t e;
    int k = 0;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) sel = resel;
      if (k == drop_k) sel_valid = 1'b0;
      e = sb.pop_front();
      chk(nm, 32'(now_obs()), 32'(e));
    end
  endtask

  task automatic issue(logic [1:0] s, logic off);
    int n = 0;
    @(negedge clk);
    while (!sel_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(sel_ready), 32'd1);
    sel_valid = 1'b1;
    sel = s;
    sel_off = off;
  endtask

  // invariant watcher: one-hot-or-zero, and a full gap before any new enable
  logic [3:0] prev_en = DEF_EN;
  int zrun = 0;
  always @(negedge clk) begin
    chk("onehot0", 32'($countones(en) <= 1), 32'd1);
    if (!nreset) begin
      prev_en = DEF_EN;
      zrun = 0;
    end else begin
      if (en != 4'b0000 && en != prev_en)
        chk("gap_before_enable",
            32'(prev_en == 4'b0000 && zrun >= GAP), 32'd1);
      zrun = (en == 4'b0000) ? zrun + 1 : 0;
      prev_en = en;
    end
  end

  typedef struct {
    logic [1:0] s;
    logic       off;
    logic       sw;
    logic [3:0] exp_en;
    logic       exp_on;
    logic [1:0] exp_cs;
  } vec_t;

  vec_t tbl[9];
  logic pr;

  initial begin
    tbl = '{
      '{2'd0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0},
      '{2'd0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0},
      '{2'd0, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0},
      '{2'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0},
      '{2'd0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0},
      '{2'd1, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1},
      '{2'd3, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3},
      '{2'd3, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3},
      '{2'd2, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2}
    };

    #12;
    chk("reset_en", 32'(en), 32'(DEF_EN));
    chk("reset_cur_sel", 32'(cur_sel), 32'd2);
    chk("reset_state", 32'({cur_on, sel_ready, busy, err}), 32'b1100);
    chk("reset_en3", 32'(en3), 32'b001);
    @(posedge clk);
    #3 nreset = 1'b1;

    foreach (tbl[i]) begin
      issue(tbl[i].s, tbl[i].off);
      if (tbl[i].sw) begin
        push_switch(tbl[i].exp_en, tbl[i].exp_on);
      end else begin
        push(tbl[i].exp_en, 1'b1, tbl[i].exp_on, 1'b0);
        push(tbl[i].exp_en, 1'b1, tbl[i].exp_on, 1'b0);
      end
      drain("table_seq", 1, tbl[i].s);
      chk("table_cur_sel", 32'(cur_sel), 32'(tbl[i].exp_cs));
    end
    sel_off = 1'b0;

    // request held through a switch is taken once ready returns
    issue(2'd3, 1'b0);
    push_switch(4'b1000, 1'b1);
    push_switch(4'b0010, 1'b1);
    drain("held_req", GAP + 3, 2'd1);
    chk("held_cur_sel", 32'(cur_sel), 32'd1);

    // out-of-range select, and single-cycle gap
    @(negedge clk);
    v3 = 1'b1;
    s3 = 2'd3;
    @(posedge clk);
    #1 v3 = 1'b0;
    chk("err_pulse", 32'({e3, r3, on3, en3}), 32'b111001);
    @(posedge clk);
    #1 chk("err_clear", 32'({e3, r3, en3}), 32'b01001);
    @(negedge clk);
    v3 = 1'b1;
    s3 = 2'd2;
    @(posedge clk);
    #1 v3 = 1'b0;
    chk("gap1_zero", 32'({r3, b3, en3}), 32'b01000);
    @(posedge clk);
    #1 chk("gap1_on", 32'({r3, en3, cs3}), 32'b010010);
    @(posedge clk);
    #1 chk("gap1_ready", 32'({r3, b3}), 32'b10);

    // async reset in the middle of a gap
    issue(2'd0, 1'b0);
    @(posedge clk);
    #1 sel_valid = 1'b0;
    chk("pre_reset_gap", 32'(en), 32'd0);
    @(posedge clk);
    #3 nreset = 1'b0;
    #1;
    chk("async_rst_en", 32'(en), 32'(DEF_EN));
    chk("async_rst_st", 32'({cur_sel, cur_on, sel_ready, busy}), 32'b10110);
    @(posedge clk);
    @(posedge clk);
    #3 nreset = 1'b1;
    repeat (GAP + 2) begin
      @(posedge clk);
      #1 chk("post_rst_idle", 32'({en, sel_ready}), 32'({DEF_EN, 1'b1}));
    end

    // random requests under the invariant watcher
    pr = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (!sel_valid || pr) begin
        sel_valid = 1'($urandom_range(0, 1));
        sel = 2'($urandom_range(0, 3));
        sel_off = ($urandom_range(0, 7) == 0);
      end
      pr = sel_valid && sel_ready;
    end
    @(negedge clk);
    sel_valid = 1'b0;
    repeat (GAP + 4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
